// File: rtl/common.sv
// Shared types for the SRAM arbiter.
// Holds the FSM state and requester id enums, the bus widths, and the
// latched transfer record (address, write data, direction).
package common;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    STROBE = 2'd2
  } sram_arb_state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_SCR  = 2'd1,
    REQ_INIT = 2'd2,
    REQ_CPU  = 2'd3
  } sram_req_id_t;

  // One SRAM transfer as captured at grant time.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
  } sram_xfer_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side signal bundle for sram_arbiter.
// slave  : arbiter view (requests and sram_di in; acks, rdata, cpu_wait and
//          SRAM address/data/strobes out).
// master : environment view (the reverse).
interface sram_arbiter_if;
  import common::*;

  // screen fetch (read only)
  logic              scr_req;
  logic [ADDR_W-1:0] scr_addr;
  logic              scr_ack;
  // memory initializer (write only)
  logic              init_req;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_wdata;
  logic              init_ack;
  // CPU (read or write)
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              cpu_wait;
  // shared read data
  logic [DATA_W-1:0] rdata;
  // SRAM pins
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_do;
  logic [DATA_W-1:0] sram_di;
  logic              sram_oe;
  logic              n_vrd;
  logic              n_vwr;

  modport slave (
    input  scr_req, scr_addr,
    input  init_req, init_addr, init_wdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  sram_di,
    output scr_ack, init_ack, cpu_ack, cpu_wait, rdata,
    output sram_a, sram_do, sram_oe, n_vrd, n_vwr
  );

  modport master (
    output scr_req, scr_addr,
    output init_req, init_addr, init_wdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output sram_di,
    input  scr_ack, init_ack, cpu_ack, cpu_wait, rdata,
    input  sram_a, sram_do, sram_oe, n_vrd, n_vwr
  );

endinterface

// File: rtl/sram_arbiter.sv
// Three-way SRAM arbiter: screen fetch, memory initializer and CPU share one
// asynchronous SRAM. Priority scr > starved cpu > init > cpu, decided only when
// the FSM enters ADDR. Each access is one ADDR cycle followed by STROBE_CYCLES
// strobe cycles; the ack pulses in the cycle after the last strobe.
// Ports: clk28, rst_n (async, active-low), bus (sram_arbiter_if.slave).
module sram_arbiter
  import common::*;
#(
  parameter int unsigned STARVE_LIMIT  = 12,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input logic           clk28,
  input logic           rst_n,
  sram_arbiter_if.slave bus
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CW = $clog2(STROBE_CYCLES + 1);

  sram_arb_state_t   state_q, state_d;
  logic [CW-1:0]     strobe_cnt_q, strobe_cnt_d;
  sram_req_id_t      cur_id_q, cur_id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] sram_a_q, sram_a_d;
  logic [DATA_W-1:0] sram_do_q, sram_do_d;
  logic              sram_oe_q, sram_oe_d;
  logic              n_vrd_q, n_vrd_d;
  logic              n_vwr_q, n_vwr_d;
  logic              scr_ack_q, scr_ack_d;
  logic              init_ack_q, init_ack_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cpu_wait_q, cpu_wait_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;

  logic         scr_p, init_p, cpu_p, any_p;
  logic         promoted, last_strobe, grant;
  sram_req_id_t win_id;
  sram_xfer_t   win_x;

  // A requester whose access is finishing still holds req until it sees its
  // ack, so it is excluded from the arbitration that ends its own access.
  always_comb begin
    scr_p       = bus.scr_req  && (cur_id_q != REQ_SCR);
    init_p      = bus.init_req && (cur_id_q != REQ_INIT);
    cpu_p       = bus.cpu_req  && (cur_id_q != REQ_CPU);
    any_p       = scr_p || init_p || cpu_p;
    promoted    = (starve_cnt_q == SW'(STARVE_LIMIT));
    last_strobe = (strobe_cnt_q == CW'(STROBE_CYCLES - 1));
  end

  // Fixed-priority encoder with the starved CPU slotted above init.
  always_comb begin
    win_id = REQ_NONE;
    win_x  = '0;
    if (scr_p) begin
      win_id = REQ_SCR;
      win_x  = '{addr: bus.scr_addr, wdata: DATA_W'(0), we: 1'b0};
    end else if (cpu_p && promoted) begin
      win_id = REQ_CPU;
      win_x  = '{addr: bus.cpu_addr, wdata: bus.cpu_wdata, we: bus.cpu_we};
    end else if (init_p) begin
      win_id = REQ_INIT;
      win_x  = '{addr: bus.init_addr, wdata: bus.init_wdata, we: 1'b1};
    end else if (cpu_p) begin
      win_id = REQ_CPU;
      win_x  = '{addr: bus.cpu_addr, wdata: bus.cpu_wdata, we: bus.cpu_we};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    strobe_cnt_d = strobe_cnt_q;
    cur_id_d     = cur_id_q;
    we_d         = we_q;
    sram_a_d     = sram_a_q;
    sram_do_d    = sram_do_q;
    sram_oe_d    = sram_oe_q;
    n_vrd_d      = 1'b1;
    n_vwr_d      = 1'b1;
    scr_ack_d    = 1'b0;
    init_ack_d   = 1'b0;
    cpu_ack_d    = 1'b0;
    rdata_d      = rdata_q;
    grant        = 1'b0;

    unique case (state_q)
      IDLE: begin
        grant = any_p;
      end
      ADDR: begin
        state_d      = STROBE;
        strobe_cnt_d = '0;
        n_vrd_d      = we_q;
        n_vwr_d      = !we_q;
      end
      STROBE: begin
        if (!last_strobe) begin
          strobe_cnt_d = strobe_cnt_q + CW'(1);
          n_vrd_d      = we_q;
          n_vwr_d      = !we_q;
        end else begin
          scr_ack_d  = (cur_id_q == REQ_SCR);
          init_ack_d = (cur_id_q == REQ_INIT);
          cpu_ack_d  = (cur_id_q == REQ_CPU);
          if (!we_q) begin
            rdata_d = bus.sram_di;
          end
          sram_oe_d = 1'b0;
          cur_id_d  = REQ_NONE;
          if (any_p) begin
            grant = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Grant: latch the winner as the FSM enters ADDR.
    if (grant) begin
      state_d   = ADDR;
      cur_id_d  = win_id;
      we_d      = win_x.we;
      sram_a_d  = win_x.addr;
      sram_oe_d = win_x.we;
      if (win_x.we) begin
        sram_do_d = win_x.wdata;
      end
    end
  end

  // Starve counter and cpu_wait track the CPU request level independently.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.cpu_req || cpu_ack_q) begin
      starve_cnt_d = '0;
    end else if (!promoted) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
    cpu_wait_d = bus.cpu_req && !cpu_ack_d && !cpu_ack_q;
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      strobe_cnt_q <= '0;
      cur_id_q     <= REQ_NONE;
      we_q         <= 1'b0;
      sram_a_q     <= '0;
      sram_do_q    <= '0;
      sram_oe_q    <= 1'b0;
      n_vrd_q      <= 1'b1;
      n_vwr_q      <= 1'b1;
      scr_ack_q    <= 1'b0;
      init_ack_q   <= 1'b0;
      cpu_ack_q    <= 1'b0;
      rdata_q      <= '0;
      cpu_wait_q   <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      strobe_cnt_q <= strobe_cnt_d;
      cur_id_q     <= cur_id_d;
      we_q         <= we_d;
      sram_a_q     <= sram_a_d;
      sram_do_q    <= sram_do_d;
      sram_oe_q    <= sram_oe_d;
      n_vrd_q      <= n_vrd_d;
      n_vwr_q      <= n_vwr_d;
      scr_ack_q    <= scr_ack_d;
      init_ack_q   <= init_ack_d;
      cpu_ack_q    <= cpu_ack_d;
      rdata_q      <= rdata_d;
      cpu_wait_q   <= cpu_wait_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.sram_a   = sram_a_q;
  assign bus.sram_do  = sram_do_q;
  assign bus.sram_oe  = sram_oe_q;
  assign bus.n_vrd    = n_vrd_q;
  assign bus.n_vwr    = n_vwr_q;
  assign bus.scr_ack  = scr_ack_q;
  assign bus.init_ack = init_ack_q;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.cpu_wait = cpu_wait_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a table of single transactions from
// idle, then hand-written sequences for contention, cancellation, CPU
// starvation/promotion and reset during a write strobe.
module tb_sram_arbiter;
  import common::*;

  logic clk28 = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  sram_arbiter_if bus ();

  sram_arbiter #(.STARVE_LIMIT(12), .STROBE_CYCLES(2)) dut (
    .clk28 (clk28),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk28 = ~clk28;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // src: 0 = screen, 1 = init, 2 = cpu
  typedef struct {
    int          src;
    logic        we;
    logic [18:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  di;
    int          exp_rd_lo;
    int          exp_wr_lo;
    logic [7:0]  exp_rdata;
    logic [7:0]  exp_do;
    logic        exp_wait;
  } vec_t;

  vec_t vecs [6];

  // One isolated transaction started right after a posedge from IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    int          rd_lo = 0;
    int          wr_lo = 0;
    int          ack_cnt = 0;
    int          ack_cyc = 0;
    logic [18:0] a1 = '0;
    logic        oe1 = 1'b0;
    logic        oe3 = 1'b0;
    logic [7:0]  do3 = '0;
    logic [7:0]  rd_at_ack = '0;
    logic        wait2 = 1'b0;
    logic        ack;
    bus.sram_di = v.di;
    case (v.src)
      0: begin bus.scr_addr = v.addr; bus.scr_req = 1'b1; end
      1: begin bus.init_addr = v.addr; bus.init_wdata = v.wdata; bus.init_req = 1'b1; end
      default: begin
        bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata; bus.cpu_we = v.we; bus.cpu_req = 1'b1;
      end
    endcase
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk28); #1;
      if (!bus.n_vrd) rd_lo++;
      if (!bus.n_vwr) wr_lo++;
      if (cyc == 1) begin a1 = bus.sram_a; oe1 = bus.sram_oe; end
      if (cyc == 2) wait2 = bus.cpu_wait;
      if (cyc == 3) begin oe3 = bus.sram_oe; do3 = bus.sram_do; end
      ack = (v.src == 0) ? bus.scr_ack : (v.src == 1) ? bus.init_ack : bus.cpu_ack;
      if (ack) begin
        ack_cnt++;
        ack_cyc = cyc;
        rd_at_ack = bus.rdata;
        bus.scr_req = 1'b0; bus.init_req = 1'b0; bus.cpu_req = 1'b0;
      end
    end
    chk($sformatf("v%0d sram_a", idx), 32'(a1), 32'(v.addr));
    chk($sformatf("v%0d n_vrd low cycles", idx), 32'(rd_lo), 32'(v.exp_rd_lo));
    chk($sformatf("v%0d n_vwr low cycles", idx), 32'(wr_lo), 32'(v.exp_wr_lo));
    chk($sformatf("v%0d ack count", idx), 32'(ack_cnt), 32'd1);
    chk($sformatf("v%0d ack cycle", idx), 32'(ack_cyc), 32'd4);
    chk($sformatf("v%0d rdata", idx), 32'(rd_at_ack), 32'(v.exp_rdata));
    chk($sformatf("v%0d oe in ADDR", idx), 32'(oe1), 32'(v.we));
    chk($sformatf("v%0d oe last strobe", idx), 32'(oe3), 32'(v.we));
    chk($sformatf("v%0d sram_do", idx), 32'(do3), 32'(v.exp_do));
    chk($sformatf("v%0d cpu_wait", idx), 32'(wait2), 32'(v.exp_wait));
  endtask

  initial begin
    //          src we  addr       wdata  di     rd wr rdata  do     wait
    vecs[0] = '{2, 1'b0, 19'h12345, 8'h00, 8'hA5, 2, 0, 8'hA5, 8'h00, 1'b1};
    vecs[1] = '{2, 1'b1, 19'h00100, 8'h3C, 8'hEE, 0, 2, 8'hA5, 8'h3C, 1'b1};
    vecs[2] = '{0, 1'b0, 19'h7FFFF, 8'h00, 8'h5A, 2, 0, 8'h5A, 8'h3C, 1'b0};
    vecs[3] = '{1, 1'b1, 19'h00000, 8'hFF, 8'h77, 0, 2, 8'h5A, 8'hFF, 1'b0};
    vecs[4] = '{2, 1'b0, 19'h40000, 8'h99, 8'h00, 2, 0, 8'h00, 8'hFF, 1'b1};
    vecs[5] = '{0, 1'b0, 19'h00001, 8'h00, 8'hC3, 2, 0, 8'hC3, 8'hFF, 1'b0};

    bus.scr_req = 1'b0;  bus.scr_addr = '0;
    bus.init_req = 1'b0; bus.init_addr = '0; bus.init_wdata = '0;
    bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.sram_di = '0;

    // Reset values while rst_n is held low.
    repeat (2) @(posedge clk28);
    #1;
    chk("rst n_vrd", 32'(bus.n_vrd), 32'd1);
    chk("rst n_vwr", 32'(bus.n_vwr), 32'd1);
    chk("rst sram_oe", 32'(bus.sram_oe), 32'd0);
    chk("rst acks", 32'({bus.scr_ack, bus.init_ack, bus.cpu_ack}), 32'd0);
    chk("rst rdata", 32'(bus.rdata), 32'd0);
    chk("rst sram_a", 32'(bus.sram_a), 32'd0);
    chk("rst sram_do", 32'(bus.sram_do), 32'd0);
    chk("rst cpu_wait", 32'(bus.cpu_wait), 32'd0);
    chk("rst starve", 32'(dut.starve_cnt_q), 32'd0);
    chk("rst state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk28) rst_n = 1'b1;
    @(posedge clk28); #1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Screen and CPU write together: screen first, CPU strobe 3 cycles later.
    begin
      int scr_cyc = 0, cpu_cyc = 0, wr_first = 0, rd_lo = 0;
      logic [18:0] a1 = '0, a4 = '0;
      logic oe4 = 1'b0;
      logic [7:0] do_first = '0, rd7 = '0;
      bus.scr_addr = 19'h00200; bus.sram_di = 8'h11; bus.scr_req = 1'b1;
      bus.cpu_addr = 19'h00100; bus.cpu_wdata = 8'h3C; bus.cpu_we = 1'b1; bus.cpu_req = 1'b1;
      for (int cyc = 1; cyc <= 9; cyc++) begin
        @(posedge clk28); #1;
        if (!bus.n_vrd) rd_lo++;
        if (!bus.n_vwr && wr_first == 0) begin wr_first = cyc; do_first = bus.sram_do; end
        if (cyc == 1) a1 = bus.sram_a;
        if (cyc == 4) begin a4 = bus.sram_a; oe4 = bus.sram_oe; end
        if (bus.scr_ack) begin scr_cyc = cyc; bus.scr_req = 1'b0; end
        if (bus.cpu_ack) begin cpu_cyc = cyc; rd7 = bus.rdata; bus.cpu_req = 1'b0; end
      end
      chk("pri first addr", 32'(a1), 32'h00200);
      chk("pri scr ack cycle", 32'(scr_cyc), 32'd4);
      chk("pri scr read strobes", 32'(rd_lo), 32'd2);
      chk("pri cpu addr", 32'(a4), 32'h00100);
      chk("pri cpu oe in ADDR", 32'(oe4), 32'd1);
      chk("pri cpu n_vwr start", 32'(wr_first), 32'd5);
      chk("pri cpu sram_do", 32'(do_first), 32'h3C);
      chk("pri cpu ack cycle", 32'(cpu_cyc), 32'd7);
      chk("pri rdata held", 32'(rd7), 32'h11);
    end

    // CPU request withdrawn before it could be granted.
    begin
      int cpu_acks = 0, wr_lo = 0, scr_acks = 0;
      logic w2 = 1'b0, w3 = 1'b1;
      bus.scr_addr = 19'h00300; bus.sram_di = 8'h22; bus.scr_req = 1'b1;
      bus.cpu_addr = 19'h00400; bus.cpu_wdata = 8'h44; bus.cpu_we = 1'b1;
      for (int cyc = 1; cyc <= 8; cyc++) begin
        @(posedge clk28); #1;
        if (!bus.n_vwr) wr_lo++;
        if (bus.cpu_ack) cpu_acks++;
        if (bus.scr_ack) begin scr_acks++; bus.scr_req = 1'b0; end
        if (cyc == 2) w2 = bus.cpu_wait;
        if (cyc == 3) w3 = bus.cpu_wait;
        if (cyc == 1) bus.cpu_req = 1'b1;
        if (cyc == 2) bus.cpu_req = 1'b0;
      end
      chk("cancel cpu acks", 32'(cpu_acks), 32'd0);
      chk("cancel n_vwr cycles", 32'(wr_lo), 32'd0);
      chk("cancel scr acks", 32'(scr_acks), 32'd1);
      chk("cancel cpu_wait while pending", 32'(w2), 32'd1);
      chk("cancel cpu_wait after drop", 32'(w3), 32'd0);
      chk("cancel starve cleared", 32'(dut.starve_cnt_q), 32'd0);
    end

    // Continuous init and screen traffic: the CPU loses to init until the
    // starve counter saturates, then wins the next slot screen leaves open.
    begin
      int cpu_cyc = 0, cpu_acks = 0, init_before = 0, init_after = 0;
      logic [31:0] s11 = '0, s12 = '0, s15 = '0, s20 = '1;
      logic w5 = 1'b0;
      bus.scr_addr = 19'h00500; bus.scr_req = 1'b1;
      bus.init_addr = 19'h00600; bus.init_wdata = 8'h66; bus.init_req = 1'b1;
      bus.cpu_addr = 19'h0ABCD; bus.cpu_we = 1'b0; bus.sram_di = 8'h5E; bus.cpu_req = 1'b1;
      for (int cyc = 1; cyc <= 26; cyc++) begin
        @(posedge clk28); #1;
        if (cyc == 5)  w5 = bus.cpu_wait;
        if (cyc == 11) s11 = 32'(dut.starve_cnt_q);
        if (cyc == 12) s12 = 32'(dut.starve_cnt_q);
        if (cyc == 15) s15 = 32'(dut.starve_cnt_q);
        if (cyc == 20) s20 = 32'(dut.starve_cnt_q);
        if (bus.cpu_ack) begin cpu_acks++; cpu_cyc = cyc; bus.cpu_req = 1'b0; end
        if (bus.init_ack) begin
          if (cpu_acks == 0) init_before++;
          else if (init_after == 0) init_after = cyc;
        end
      end
      bus.scr_req = 1'b0; bus.init_req = 1'b0;
      chk("starve cpu_wait", 32'(w5), 32'd1);
      chk("starve count 11", s11, 32'd11);
      chk("starve count 12", s12, 32'd12);
      chk("starve saturated", s15, 32'd12);
      chk("starve cpu ack cycle", 32'(cpu_cyc), 32'd19);
      chk("starve cpu ack count", 32'(cpu_acks), 32'd1);
      chk("starve init acks before cpu", 32'(init_before), 32'd2);
      chk("starve next init ack", 32'(init_after), 32'd25);
      chk("starve cleared after ack", s20, 32'd0);
      repeat (8) @(posedge clk28);
      #1;
    end

    // Reset asserted during the first strobe cycle of a CPU write.
    begin
      int acks = 0;
      bus.cpu_addr = 19'h01234; bus.cpu_wdata = 8'h77; bus.cpu_we = 1'b1; bus.cpu_req = 1'b1;
      @(posedge clk28); #1;
      chk("mid-rst oe in ADDR", 32'(bus.sram_oe), 32'd1);
      @(posedge clk28); #1;
      chk("mid-rst n_vwr strobe", 32'(bus.n_vwr), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid-rst n_vwr released", 32'(bus.n_vwr), 32'd1);
      chk("mid-rst oe released", 32'(bus.sram_oe), 32'd0);
      chk("mid-rst sram_a", 32'(bus.sram_a), 32'd0);
      bus.cpu_req = 1'b0;
      @(negedge clk28) rst_n = 1'b1;
      for (int cyc = 1; cyc <= 6; cyc++) begin
        @(posedge clk28); #1;
        if (bus.cpu_ack || bus.scr_ack || bus.init_ack) acks++;
      end
      chk("mid-rst no ack", 32'(acks), 32'd0);
      chk("mid-rst idle", 32'(dut.state_q), 32'(IDLE));
      chk("mid-rst n_vwr idle", 32'(bus.n_vwr), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
